// File: rtl/hspi_io_bridge_if.sv
// rtl/hspi_io_bridge_if.sv - HSPI core, data-pad and sideband signal bundle
interface hspi_io_bridge_if #(
    parameter int DW  = 16,
    parameter int NSB = 6
);
    logic           core_oen;
    logic           core_tx_enable;
    logic [DW-1:0]  core_tx_data;
    logic           core_rx_enable;
    logic [DW-1:0]  core_rx_data;
    logic [DW-1:0]  pad_in;
    logic [DW-1:0]  pad_out;
    logic [DW-1:0]  pad_oeb;
    logic           pad_rx_en_in;
    logic           pad_tx_en_out;
    logic [NSB-1:0] sb_async;
    logic [NSB-1:0] sb_sync;
    logic           turn_busy;

    modport master (
        output core_oen, core_tx_enable, core_tx_data, pad_in, pad_rx_en_in, sb_async,
        input  core_rx_enable, core_rx_data, pad_out, pad_oeb, pad_tx_en_out, sb_sync, turn_busy
    );

    modport slave (
        input  core_oen, core_tx_enable, core_tx_data, pad_in, pad_rx_en_in, sb_async,
        output core_rx_enable, core_rx_data, pad_out, pad_oeb, pad_tx_en_out, sb_sync, turn_busy
    );
endinterface

// File: rtl/hspi_io_bridge.sv
// rtl/hspi_io_bridge.sv - registered HSPI pad bridge with turnaround FSM and sideband sync/filter
module hspi_io_bridge #(
    parameter int DW          = 16,
    parameter int NSB         = 6,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYC    = 2,
    parameter int FILT        = 3
) (
    input  logic           clock,
    input  logic           reset,
    hspi_io_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    localparam int             TW    = $clog2(TURN_CYC + 1);
    localparam logic [TW-1:0]  TLOAD = TW'(TURN_CYC - 1);
    localparam int             FW    = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [FW-1:0]  FLAST = FW'(FILT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RX;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Any direction change passes through a full turnaround; a reversal mid-turn restarts or aborts it.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_RX: begin
                if (!bus.core_oen) begin
                    state_d = ST_TURN_TX;
                    tcnt_d  = TLOAD;
                end
            end
            ST_TURN_TX: begin
                if (bus.core_oen) begin
                    state_d = ST_RX;
                end else if (tcnt_q == '0) begin
                    state_d = ST_TX;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            ST_TX: begin
                if (bus.core_oen) begin
                    state_d = ST_TURN_RX;
                    tcnt_d  = TLOAD;
                end
            end
            ST_TURN_RX: begin
                if (!bus.core_oen) begin
                    state_d = ST_TURN_TX;
                    tcnt_d  = TLOAD;
                end else if (tcnt_q == '0) begin
                    state_d = ST_RX;
                end else begin
                    tcnt_d = tcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_RX;
                tcnt_d  = '0;
            end
        endcase
    end

    logic [DW-1:0] pad_out_q;
    logic          pad_tx_en_q;
    logic [DW-1:0] rx_data_q;
    logic          rx_en_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pad_out_q   <= '0;
            pad_tx_en_q <= 1'b0;
            rx_data_q   <= '0;
            rx_en_q     <= 1'b0;
        end else begin
            pad_out_q   <= bus.core_tx_data;
            pad_tx_en_q <= (state_q == ST_TX) & bus.core_tx_enable;
            rx_data_q   <= (state_q == ST_RX) ? bus.pad_in : '0;
            rx_en_q     <= (state_q == ST_RX) & bus.pad_rx_en_in;
        end
    end

    // Output enable decodes the state flop only, so reset releases the pads asynchronously.
    assign bus.pad_oeb        = (state_q == ST_TX) ? '0 : '1;
    assign bus.turn_busy      = (state_q == ST_TURN_TX) || (state_q == ST_TURN_RX);
    assign bus.pad_out        = pad_out_q;
    assign bus.pad_tx_en_out  = pad_tx_en_q;
    assign bus.core_rx_data   = rx_data_q;
    assign bus.core_rx_enable = rx_en_q;

    logic [NSB-1:0] sync_q [SYNC_STAGES];
    logic [NSB-1:0] sb_q;
    logic [FW-1:0]  fcnt_q [NSB];
    logic [NSB-1:0] s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.sb_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Each bit counts consecutive disagreeing samples; any agreement resets the run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_q <= '0;
            for (int b = 0; b < NSB; b++) begin
                fcnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NSB; b++) begin
                if (s[b] == sb_q[b]) begin
                    fcnt_q[b] <= '0;
                end else if (fcnt_q[b] == FLAST) begin
                    sb_q[b]   <= s[b];
                    fcnt_q[b] <= '0;
                end else begin
                    fcnt_q[b] <= fcnt_q[b] + FW'(1);
                end
            end
        end
    end

    assign bus.sb_sync = sb_q;
endmodule
